fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the microcoded control unit. Holds the PC and issues single-beat reads to instruction memory. Presents the fetched word and its opcode/funct3/funct7 fields to decode with a valid/ready handshake. Computes the next PC from the branch/jump control signals and ALU flags returned for the instruction being accepted.

---
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the microcoded control unit.
// Holds the PC, issues single-beat reads to instruction memory, presents the
// fetched word to decode with valid/ready, and computes the next PC from the
// branch/jump controls and ALU flags returned for the accepted instruction.
// Optional build macro FETCH_PERF_COUNT_EN adds saturating retire/redirect
// counters (perf_retired, perf_redirect).
module fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
   parameter int unsigned        INSTR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [6:0]         opcode,
   output logic [2:0]         funct3,
   output logic [6:0]         funct7,
   output logic [ADDR_W-1:0]  pc,
   input  logic               con_beq,
   input  logic               con_blt,
   input  logic               con_jalr,
   input  logic               alu_zero,
   input  logic               alu_lt,
   input  logic [ADDR_W-1:0]  imm,
   input  logic [ADDR_W-1:0]  alu_result,
`ifdef FETCH_PERF_COUNT_EN
   output logic [31:0]        perf_retired,
   output logic [31:0]        perf_redirect,
`endif
   output logic               fetch_err
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic               fetch_err_q, fetch_err_d;
   // Low for the first cycle out of reset so the first request lands in the
   // cycle after rst_n is sampled high rather than while reset is asserted.
   logic               started_q, started_d;

   logic [ADDR_W-1:0]  pc_plus4;
   logic [ADDR_W-1:0]  next_pc;
   logic               accept;
   logic               taken;

   // Next-PC selection: JALR dominates, then any true branch condition, else sequential.
   always_comb begin
      pc_plus4 = pc_q + ADDR_W'(4);
      taken    = (con_beq & alu_zero) | (con_blt & alu_lt);
      accept   = (state_q == S_HOLD) & instr_valid_q & instr_ready;
      if (con_jalr) begin
         next_pc = alu_result & ~ADDR_W'(1);
      end else if (taken) begin
         next_pc = pc_q + imm;
      end else begin
         next_pc = pc_plus4;
      end
   end

   // Fetch sequencing: REQ -> WAIT -> HOLD -> REQ, or trap in ERR on a misaligned target.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q;
      started_d     = 1'b1;
      case (state_q)
         S_REQ: begin
            if (started_q) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (accept) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               if (next_pc[1:0] != 2'b00) begin
                  fetch_err_d = 1'b1;
                  state_d     = S_ERR;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_ERR: begin
            instr_valid_d = 1'b0;
            fetch_err_d   = 1'b1;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         started_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
         started_q     <= started_d;
      end
   end

   assign imem_req    = (state_q == S_REQ) & started_q;
   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign funct3      = instr_q[14:12];
   assign funct7      = instr_q[31:25];
   assign pc          = pc_q;
   assign fetch_err   = fetch_err_q;

`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] perf_retired_q, perf_retired_d;
   logic [31:0] perf_redirect_q, perf_redirect_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Count accepts, and accepts whose target differs from the sequential PC.
   always_comb begin
      perf_retired_d  = perf_retired_q;
      perf_redirect_d = perf_redirect_q;
      if (accept) begin
         perf_retired_d = sat_inc(perf_retired_q);
         if (next_pc != pc_plus4) begin
            perf_redirect_d = sat_inc(perf_redirect_q);
         end
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_retired_q  <= '0;
         perf_redirect_q <= '0;
      end else begin
         perf_retired_q  <= perf_retired_d;
         perf_redirect_q <= perf_redirect_d;
      end
   end

   assign perf_retired  = perf_retired_q;
   assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit; expected fetch addresses are
// queued when an instruction is accepted and compared when imem_req appears.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] pc;
   logic        con_beq, con_blt, con_jalr, alu_zero, alu_lt;
   logic [31:0] imm, alu_result;
   logic        fetch_err;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] perf_retired, perf_redirect;
`endif

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .pc(pc),
      .con_beq(con_beq), .con_blt(con_blt), .con_jalr(con_jalr),
      .alu_zero(alu_zero), .alu_lt(alu_lt),
      .imm(imm), .alu_result(alu_result),
`ifdef FETCH_PERF_COUNT_EN
      .perf_retired(perf_retired), .perf_redirect(perf_redirect),
`endif
      .fetch_err(fetch_err)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   int          t0;
   int          n_acc = 0;
   int          n_redir = 0;
   logic [31:0] cur_pc = '0;
   logic [31:0] exp_q[$];

   localparam logic [31:0] W0 = 32'h4020_D0B3;
   localparam logic [31:0] W1 = 32'h00A0_0093;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a request and compare its address with the scoreboard head.
   task automatic wait_req();
      int n;
      logic [31:0] e;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("imem_req_seen", {31'd0, imem_req}, 32'd1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("imem_addr", imem_addr, e);
         cur_pc = e;
      end
      req_cyc = cyc;
   endtask

   // Request, one-cycle memory response, then the held instruction is checked.
   task automatic fetch(input logic [31:0] word);
      wait_req();
      step();
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      chk("instr_valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, word);
      chk("pc", pc, cur_pc);
   endtask

   // Accept the held instruction with the given controls; queue the expected target.
   task automatic accept(input logic jalr, input logic beq, input logic blt,
                         input logic zero, input logic lt,
                         input logic [31:0] immv, input logic [31:0] res,
                         input logic [31:0] expect_pc);
      con_jalr = jalr; con_beq = beq; con_blt = blt;
      alu_zero = zero; alu_lt = lt; imm = immv; alu_result = res;
      instr_ready = 1'b1;
      exp_q.push_back(expect_pc);
      n_acc++;
      if (expect_pc != cur_pc + 32'd4) n_redir++;
      step();
      instr_ready = 1'b0;
      con_jalr = 1'b0; con_beq = 1'b0; con_blt = 1'b0;
      alu_zero = 1'b0; alu_lt = 1'b0; imm = '0; alu_result = '0;
   endtask

   initial begin
      rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      con_beq = 1'b0; con_blt = 1'b0; con_jalr = 1'b0;
      alu_zero = 1'b0; alu_lt = 1'b0; imm = '0; alu_result = '0;
      step(); step(); step();

      // Reset state
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_opcode", {25'd0, opcode}, 32'h0);
      chk("rst_funct3", {29'd0, funct3}, 32'h0);
      chk("rst_funct7", {25'd0, funct7}, 32'h0);
      chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

      // Sequential fetch: 0x0, 0x4, 0x8 at one request per 3 cycles
      rst_n = 1'b1;
      t0 = cyc;
      exp_q.push_back(32'h0);
      fetch(W0);
      chk("first_req_latency", req_cyc - t0, 32'd1);
      chk("opcode", {25'd0, opcode}, 32'h33);
      chk("funct3", {29'd0, funct3}, 32'h5);
      chk("funct7", {25'd0, funct7}, 32'h20);
      accept(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);
      t0 = req_cyc;
      fetch(W0);
      chk("req_spacing_1", req_cyc - t0, 32'd3);
      accept(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8);
      t0 = req_cyc;
      fetch(W0);
      chk("req_spacing_2", req_cyc - t0, 32'd3);

      // Branches and jumps
      accept(0, 1, 0, 1, 0, 32'h10, 32'h0, 32'h18);         // beq taken
      fetch(W0);
      accept(1, 0, 0, 0, 0, 32'h0, 32'h9, 32'h8);           // jalr clears bit 0
      fetch(W0);
      accept(0, 1, 0, 0, 0, 32'h10, 32'h0, 32'hC);          // beq not taken
      fetch(W0);
      accept(1, 0, 0, 0, 0, 32'h0, 32'h21, 32'h20);
      fetch(W0);
      accept(0, 0, 1, 0, 1, 32'hFFFF_FFF8, 32'h0, 32'h18);  // blt backward
      fetch(W0);
      accept(1, 1, 0, 1, 0, 32'h40, 32'h101, 32'h100);      // jalr dominates beq
      fetch(W0);
      accept(0, 1, 1, 0, 1, 32'h8, 32'h0, 32'h108);         // both branch types, lt true
      fetch(W0);
      accept(1, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
      fetch(W0);
      accept(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);           // wrap to zero
      chk("wrap_no_err", {31'd0, fetch_err}, 32'd0);

      // Stall in HOLD for 5 cycles
      fetch(W1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_instr", instr, W1);
         chk("stall_opcode", {25'd0, opcode}, 32'h13);
         chk("stall_pc", pc, 32'h0);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      end
      accept(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

      // Misaligned branch target traps in ERR
      fetch(W0);
      accept(0, 1, 0, 1, 0, 32'h2, 32'h0, 32'h6);
      chk("err_flag", {31'd0, fetch_err}, 32'd1);
      chk("err_valid", {31'd0, instr_valid}, 32'd0);
      chk("err_pc", pc, exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         step();
         chk("err_no_req", {31'd0, imem_req}, 32'd0);
         chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      end
`ifdef FETCH_PERF_COUNT_EN
      chk("perf_retired", perf_retired, n_acc);
      chk("perf_redirect", perf_redirect, n_redir);
`endif

      // Reset exits ERR
      rst_n = 1'b0;
      step();
      chk("err_rst_flag", {31'd0, fetch_err}, 32'd0);
      chk("err_rst_addr", imem_addr, 32'h0);
      rst_n = 1'b1;
      n_acc = 0; n_redir = 0;
      exp_q.push_back(32'h0);
      fetch(W0);
      accept(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

      // Reset while waiting for memory
      wait_req();
      step();
      rst_n = 1'b0;
      step();
      chk("wait_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_rst_req", {31'd0, imem_req}, 32'd0);
      chk("wait_rst_pc", pc, 32'h0);
      rst_n = 1'b1;
      exp_q.push_back(32'h0);
      fetch(W1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
